// File: rtl/intt_pkg.sv
// Shared types and defaults for the inverse-NTT stage sequencer.
// Holds the FSM state enum, log field and address typedefs.
package intt_pkg;

  localparam int LOG_N_DEF          = 12;
  localparam int LOG_CORE_COUNT_DEF = 5;
  localparam int ADDR_W_DEF         = 9;

  localparam int WORDS_PER_STAGE =
    1 << (LOG_N_DEF - LOG_CORE_COUNT_DEF - 2);

  typedef logic [3:0] logf_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/intt_addr_gen.sv
// Read-address pair generator: word counter, bank bit, held outputs.
// Ports: clr/inc counter controls, bank in; cnt_last, addr[1:0] out.
module intt_addr_gen
  import intt_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = 5,
  parameter int WORDS  = WORDS_PER_STAGE
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clr,
  input  logic                   inc,
  input  logic                   bank,
  output logic                   cnt_last,
  output logic [1:0][ADDR_W-1:0] addr
);

  localparam int LOW_W = ADDR_W - 1;

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0][ADDR_W-1:0] held_q, held_d;
  logic [1:0][ADDR_W-1:0] pair;
  logic [LOW_W-1:0]       base;

  always_comb begin
    base    = LOW_W'({cnt_q, 1'b0});
    pair[0] = {bank, base};
    pair[1] = {bank, base | LOW_W'(1)};
    cnt_d   = cnt_q;
    held_d  = held_q;
    if (inc) begin
      cnt_d  = cnt_q + CNT_W'(1);
      held_d = pair;
    end
    if (clr) cnt_d = '0;
  end

  assign cnt_last = (cnt_q == CNT_W'(WORDS - 1));
  // Live pair while issuing, last issued pair otherwise.
  assign addr = inc ? pair : held_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q  <= '0;
      held_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      held_q <= held_d;
    end
  end

endmodule

// File: rtl/intt_stage_sequencer.sv
// Inverse-NTT pass sequencer: stage log_m/log_t, address issue, drain.
// Ports: start/stall in; busy/done/log_m/log_t/rd_en/address_in/banks.
// Optional INTT_STAGE_SEQUENCER_PERF_EN adds perf_cycles/perf_stalls.
module intt_stage_sequencer
  import intt_pkg::*;
#(
  parameter int LOG_CORE_COUNT = LOG_CORE_COUNT_DEF,
  parameter int LOG_N          = LOG_N_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int PIPE_LAT       = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   stall,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             log_m,
  output logic [3:0]             log_t,
  output logic                   rd_en,
  output logic [1:0][ADDR_W-1:0] address_in,
  output logic                   rd_bank,
  output logic                   wr_bank,
  output logic                   last_stage
`ifdef INTT_STAGE_SEQUENCER_PERF_EN
  ,
  output logic [15:0]            perf_cycles,
  output logic [15:0]            perf_stalls
`endif
);

  localparam int WORDS =
    1 << (LOG_N - LOG_CORE_COUNT - 2);
  localparam int CNT_W =
    (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int DW =
    (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logf_t LOG_N_F = logf_t'(LOG_N);

  state_t        state_q, state_d;
  logf_t         log_m_q, log_m_d;
  logic          bank_q, bank_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          clr, inc, cnt_last;

  intt_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W),
    .WORDS  (WORDS)
  ) u_addr (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .inc      (inc),
    .bank     (bank_q),
    .cnt_last (cnt_last),
    .addr     (address_in)
  );

  always_comb begin
    state_d = state_q;
    log_m_d = log_m_q;
    bank_d  = bank_q;
    dcnt_d  = dcnt_q;
    clr     = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr = 1'b1;
        if (start) state_d = ISSUE;
      end
      ISSUE: begin
        if (!stall) begin
          inc = 1'b1;
          if (cnt_last) begin
            clr     = 1'b1;
            dcnt_d  = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!stall) begin
          if (dcnt_q == DW'(PIPE_LAT - 1)) begin
            if (log_m_q == 4'd1) begin
              // Restore stage regs now so DONE shows
              // log_m=LOG_N and last_stage stays low.
              log_m_d = LOG_N_F;
              bank_d  = 1'b0;
              state_d = DONE;
            end else begin
              log_m_d = log_m_q - 4'd1;
              bank_d  = ~bank_q;
              state_d = ISSUE;
            end
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      log_m_q <= LOG_N_F;
      bank_q  <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      log_m_q <= log_m_d;
      bank_q  <= bank_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign rd_en      = inc;
  assign log_m      = log_m_q;
  assign log_t      = LOG_N_F - log_m_q;
  assign rd_bank    = bank_q;
  assign wr_bank    = ~bank_q;
  assign last_stage = (log_m_q == 4'd1);

`ifdef INTT_STAGE_SEQUENCER_PERF_EN
  logic [15:0] pc_q, pc_d, ps_q, ps_d;

  always_comb begin
    pc_d = pc_q;
    ps_d = ps_q;
    if (state_q == IDLE) begin
      if (start) begin
        pc_d = '0;
        ps_d = '0;
      end
    end else begin
      if (state_q != DONE && pc_q != 16'hFFFF)
        pc_d = pc_q + 16'd1;
      if (stall && ps_q != 16'hFFFF)
        ps_d = ps_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q <= '0;
      ps_q <= '0;
    end else begin
      pc_q <= pc_d;
      ps_q <= ps_d;
    end
  end

  assign perf_cycles = pc_q;
  assign perf_stalls = ps_q;
`endif

endmodule

// File: tb/tb_intt_stage_sequencer.sv
// Directed testbench for intt_stage_sequencer at default parameters.
// Compares every cycle against a small cycle-level reference model.
module tb_intt_stage_sequencer;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start = 1'b0;
  logic            stall = 1'b0;
  logic            busy, done, rd_en;
  logic [3:0]      log_m, log_t;
  logic [1:0][8:0] address_in;
  logic            rd_bank, wr_bank, last_stage;
`ifdef INTT_STAGE_SEQUENCER_PERF_EN
  logic [15:0]     perf_cycles, perf_stalls;
`endif

  intt_stage_sequencer dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .log_m      (log_m),
    .log_t      (log_t),
    .rd_en      (rd_en),
    .address_in (address_in),
    .rd_bank    (rd_bank),
    .wr_bank    (wr_bank),
    .last_stage (last_stage)
`ifdef INTT_STAGE_SEQUENCER_PERF_EN
    ,
    .perf_cycles(perf_cycles),
    .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int pass_n = 0;
  int total_n = 0;

  // Reference model state: 0 idle, 1 issue, 2 drain, 3 done.
  int m_st = 0, m_s = 0, m_cnt = 0, m_dcnt = 0;
  int m_a0 = 0, m_a1 = 0;

  localparam logic [31:0] RST_VEC =
    {1'b0, 1'b0, 1'b0, 4'd12, 4'd0,
     1'b0, 1'b1, 1'b0, 9'd0, 9'd0};

  function automatic logic [31:0] obs();
    return {busy, done, rd_en, log_m, log_t,
            rd_bank, wr_bank, last_stage,
            address_in[0], address_in[1]};
  endfunction

  function automatic logic [31:0] expv(input logic sl);
    logic b, d, r, rb;
    logic [3:0] lm;
    logic [8:0] a0, a1;
    b  = (m_st != 0);
    d  = (m_st == 3);
    r  = (m_st == 1) && !sl;
    lm = (m_st == 1 || m_st == 2) ? 4'(12 - m_s) : 4'd12;
    rb = (m_st == 1 || m_st == 2) ? m_s[0] : 1'b0;
    a0 = r ? 9'(int'(rb) * 256 + 2 * m_cnt) : 9'(m_a0);
    a1 = r ? 9'(int'(rb) * 256 + 2 * m_cnt + 1) : 9'(m_a1);
    return {b, d, r, lm, 4'(12 - int'(lm)), rb, ~rb,
            (lm == 4'd1), a0, a1};
  endfunction

  task automatic model_step(input logic st, sl, rs);
    if (!rs) begin
      m_st = 0; m_s = 0; m_cnt = 0; m_dcnt = 0;
      m_a0 = 0; m_a1 = 0;
    end else begin
      case (m_st)
        0: if (st) begin
          m_st = 1; m_s = 0; m_cnt = 0;
        end
        1: if (!sl) begin
          m_a0 = (m_s % 2) * 256 + 2 * m_cnt;
          m_a1 = m_a0 + 1;
          if (m_cnt == 31) begin
            m_st = 2; m_dcnt = 0; m_cnt = 0;
          end else m_cnt++;
        end
        2: if (!sl) begin
          if (m_dcnt == 7) begin
            if (m_s == 11) m_st = 3;
            else begin
              m_s++; m_cnt = 0; m_st = 1;
            end
          end else m_dcnt++;
        end
        default: m_st = 0;
      endcase
    end
  endtask

  // Drive inputs just after a rising edge, wait to the falling edge.
  task automatic tick(input logic st, sl, rs);
    @(posedge clk);
    #1;
    start = st;
    stall = sl;
    rstn  = rs;
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b0);
    model_step(1'b1, 1'b1, 1'b0);
    total_n++;
    if (obs() !== RST_VEC)
      $display("FAIL reset_a got=%h want=%h", obs(), RST_VEC);
    else pass_n++;
    tick(1'b0, 1'b1, 1'b1);
    total_n++;
    if (obs() !== RST_VEC)
      $display("FAIL reset_b got=%h want=%h", obs(), RST_VEC);
    else pass_n++;
    model_step(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    total_n++;
    if (obs() !== expv(stall))
      $display("FAIL idle_stall got=%h want=%h", obs(), expv(stall));
    else pass_n++;
    model_step(1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_normal();
    int dc = 0, ls = 0, ren = 0;
    bit seen = 0;
    tick(1'b1, 1'b0, 1'b1);
    total_n++;
    if (obs() !== expv(stall))
      $display("FAIL norm_c0 got=%h want=%h", obs(), expv(stall));
    else pass_n++;
    model_step(1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 600; c++) begin
      tick(1'b0, 1'b0, 1'b1);
      total_n++;
      if (obs() !== expv(stall))
        $display("FAIL norm_cyc c=%0d got=%h want=%h",
                 c, obs(), expv(stall));
      else pass_n++;
      ls  += int'(last_stage);
      ren += int'(rd_en);
      if (done && !seen) begin
        seen = 1; dc = c;
      end
      model_step(1'b0, 1'b0, 1'b1);
      if (seen && c == dc + 1) break;
    end
    total_n++;
    if (!seen || dc != 481)
      $display("FAIL norm_done_cyc got=%0d want=481", dc);
    else pass_n++;
    total_n++;
    if (ls != 40)
      $display("FAIL norm_last_cnt got=%0d want=40", ls);
    else pass_n++;
    total_n++;
    if (ren != 384)
      $display("FAIL norm_rden_cnt got=%0d want=384", ren);
    else pass_n++;
  endtask

  task automatic test_stall();
    int dc = 0;
    bit seen = 0;
    logic sl;
    tick(1'b1, 1'b0, 1'b1);
    model_step(1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 600; c++) begin
      sl = ((c >= 90 && c <= 94) ||
            (c >= 120 && c <= 122));
      tick(1'b0, sl, 1'b1);
      total_n++;
      if (obs() !== expv(stall))
        $display("FAIL stall_cyc c=%0d got=%h want=%h",
                 c, obs(), expv(stall));
      else pass_n++;
      if (done && !seen) begin
        seen = 1; dc = c;
      end
      model_step(1'b0, sl, 1'b1);
      if (seen && c == dc + 1) break;
    end
    total_n++;
    if (!seen || dc != 489)
      $display("FAIL stall_done_cyc got=%0d want=489", dc);
    else pass_n++;
`ifdef INTT_STAGE_SEQUENCER_PERF_EN
    total_n++;
    if (perf_cycles !== 16'd488)
      $display("FAIL perf_cycles got=%0d want=488", perf_cycles);
    else pass_n++;
    total_n++;
    if (perf_stalls !== 16'd8)
      $display("FAIL perf_stalls got=%0d want=8", perf_stalls);
    else pass_n++;
`endif
  endtask

  task automatic test_start_ignored();
    int dn = 0;
    logic st;
    tick(1'b1, 1'b0, 1'b1);
    model_step(1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 500; c++) begin
      st = (c == 170 || c == 481);
      tick(st, 1'b0, 1'b1);
      total_n++;
      if (obs() !== expv(stall))
        $display("FAIL ign_cyc c=%0d got=%h want=%h",
                 c, obs(), expv(stall));
      else pass_n++;
      dn += int'(done);
      model_step(st, 1'b0, 1'b1);
    end
    total_n++;
    if (dn != 1)
      $display("FAIL ign_done_cnt got=%0d want=1", dn);
    else pass_n++;
    total_n++;
    if (busy !== 1'b0)
      $display("FAIL ign_no_rerun got=%b want=0", busy);
    else pass_n++;
  endtask

  task automatic test_reset_midpass();
    int dn = 0;
    logic rs;
    tick(1'b1, 1'b0, 1'b1);
    model_step(1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 300; c++) begin
      rs = (c != 275);
      tick(1'b0, 1'b0, rs);
      total_n++;
      if (obs() !== expv(stall))
        $display("FAIL rmid_cyc c=%0d got=%h want=%h",
                 c, obs(), expv(stall));
      else pass_n++;
      if (c == 276) begin
        total_n++;
        if (obs() !== RST_VEC)
          $display("FAIL rmid_rstvec got=%h want=%h",
                   obs(), RST_VEC);
        else pass_n++;
      end
      dn += int'(done);
      model_step(1'b0, 1'b0, rs);
    end
    total_n++;
    if (dn != 0)
      $display("FAIL rmid_done_cnt got=%0d want=0", dn);
    else pass_n++;
    test_normal();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_stall();
    test_start_ignored();
    test_reset_midpass();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

  initial begin
    #100000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
